wt_dcache_miss_resp: RTL and testbench

WT_DCACHE_MISS_RESP -- requirements
Module: wt_dcache_miss_resp

---
 rtl/wt_cache_pkg.sv | 42 ++++
 rtl/wt_dcache_repl_sel.sv | 42 ++++
 rtl/wt_dcache_miss_resp.sv | 148 ++++++++++++++
 tb/tb_wt_dcache_miss_resp.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// Shared types and geometry for the write-through dcache miss path.
// Holds the MSHR record, the miss FSM encoding and cache geometry constants.
package wt_cache_pkg;

    localparam int PLEN                = 32;
    localparam int DCACHE_SET_ASSOC    = 4;
    localparam int DCACHE_OFFSET_WIDTH = 5;
    localparam int DCACHE_CL_IDX_WIDTH = 7;
    localparam int CACHE_ID_WIDTH      = 3;
    localparam int DCACHE_WAY_W        = $clog2(DCACHE_SET_ASSOC);
    localparam int OWNER_W             = 8;

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        WAIT_RTRN
    } miss_state_e;

    typedef struct packed {
        logic [PLEN-1:0]             paddr;
        logic [2:0]                  size;
        logic                        nc;
        logic [OWNER_W-1:0]          owner;
        logic [DCACHE_SET_ASSOC-1:0] way;
    } mshr_t;

    // One-hot of the lowest invalid way; all-zero when every way is valid.
    function automatic logic [DCACHE_SET_ASSOC-1:0] first_zero_oh(
        input logic [DCACHE_SET_ASSOC-1:0] vld
    );
        logic [DCACHE_SET_ASSOC-1:0] oh;
        oh = '0;
        for (int i = DCACHE_SET_ASSOC-1; i >= 0; i--) begin
            if (!vld[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/wt_dcache_repl_sel.sv
// Victim-way selector used when every way of the target set is valid.
// WT_DCACHE_MISS_LFSR_EN selects a free-running LFSR; otherwise a use-stepped counter.
module wt_dcache_repl_sel
    import wt_cache_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    advance,
    output logic [DCACHE_WAY_W-1:0] way
);

`ifdef WT_DCACHE_MISS_LFSR_EN
    logic [7:0] lfsr;
    logic       unused_advance;

    assign unused_advance = advance;

    // Fibonacci LFSR, taps 8,6,5,4, steps every cycle regardless of use.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign way = lfsr[DCACHE_WAY_W-1:0];
`else
    logic [DCACHE_WAY_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= cnt + DCACHE_WAY_W'(1);
        end
    end

    assign way = cnt;
`endif

endmodule

// File: rtl/wt_dcache_miss_resp.sv
// Single-MSHR miss handler: arbitrates read-port misses, issues the refill, routes the return.
// Replacement policy is chosen at build time by WT_DCACHE_MISS_LFSR_EN (see wt_dcache_repl_sel).
module wt_dcache_miss_resp
    import wt_cache_pkg::*;
#(
    parameter int                        NumPorts = 3,
    parameter logic [CACHE_ID_WIDTH-1:0] MemTid   = CACHE_ID_WIDTH'(1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumPorts-1:0]            miss_req_i,
    output logic [NumPorts-1:0]            miss_ack_o,
    output logic [NumPorts-1:0]            miss_replay_o,
    output logic [NumPorts-1:0]            miss_rtrn_vld_o,
    input  logic [PLEN-1:0]                miss_paddr_i    [NumPorts],
    input  logic [DCACHE_SET_ASSOC-1:0]    miss_vld_bits_i [NumPorts],
    input  logic [NumPorts-1:0]            miss_nc_i,
    input  logic [2:0]                     miss_size_i     [NumPorts],
    output logic                           mem_req_o,
    input  logic                           mem_gnt_i,
    output logic [PLEN-1:0]                mem_paddr_o,
    output logic [2:0]                     mem_size_o,
    output logic                           mem_nc_o,
    output logic [CACHE_ID_WIDTH-1:0]      mem_tid_o,
    input  logic                           mem_rtrn_vld_i,
    input  logic [CACHE_ID_WIDTH-1:0]      mem_rtrn_tid_i,
    output logic                           wr_cl_vld_o,
    output logic [DCACHE_SET_ASSOC-1:0]    wr_cl_way_o,
    output logic [DCACHE_CL_IDX_WIDTH-1:0] wr_cl_idx_o,
    output logic                           busy_o
);

    localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    miss_state_e                         state, state_nxt;
    mshr_t                               mshr, mshr_nxt;
    logic [PW-1:0]                       rr_ptr, rr_ptr_nxt;
    logic                                repl_use;
    logic [DCACHE_WAY_W-1:0]             repl_way;
    logic [DCACHE_SET_ASSOC-1:0]         free_way;
    logic [PLEN-DCACHE_OFFSET_WIDTH-1:0] mshr_line;
    logic                                found;
    int                                  idx;
    int                                  win;

    wt_dcache_repl_sel u_repl_sel (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .advance (repl_use),
        .way     (repl_way)
    );

    assign mshr_line = mshr.paddr[PLEN-1:DCACHE_OFFSET_WIDTH];

    always_comb begin
        state_nxt       = state;
        mshr_nxt        = mshr;
        rr_ptr_nxt      = rr_ptr;
        repl_use        = 1'b0;
        free_way        = '0;
        found           = 1'b0;
        idx             = 0;
        win             = 0;
        miss_ack_o      = '0;
        miss_replay_o   = '0;
        miss_rtrn_vld_o = '0;
        mem_req_o       = 1'b0;
        wr_cl_vld_o     = 1'b0;

        // Same-line requests while a miss is outstanding must replay; others just stall.
        if (state != IDLE) begin
            for (int i = 0; i < NumPorts; i++) begin
                miss_replay_o[i] = miss_req_i[i] &&
                    (miss_paddr_i[i][PLEN-1:DCACHE_OFFSET_WIDTH] == mshr_line);
            end
        end

        case (state)
            IDLE: begin
                for (int k = 0; k < NumPorts; k++) begin
                    idx = int'(rr_ptr) + k;
                    if (idx >= NumPorts) idx = idx - NumPorts;
                    if (!found && miss_req_i[idx]) begin
                        found = 1'b1;
                        win   = idx;
                    end
                end
                if (found) begin
                    miss_ack_o[win] = 1'b1;
                    mshr_nxt.nc     = miss_nc_i[win];
                    mshr_nxt.owner  = OWNER_W'(win);
                    if (miss_nc_i[win]) begin
                        mshr_nxt.paddr = miss_paddr_i[win];
                        mshr_nxt.size  = miss_size_i[win];
                    end else begin
                        mshr_nxt.paddr = {miss_paddr_i[win][PLEN-1:DCACHE_OFFSET_WIDTH],
                                          {DCACHE_OFFSET_WIDTH{1'b0}}};
                        mshr_nxt.size  = 3'b111;
                    end
                    free_way = first_zero_oh(miss_vld_bits_i[win]);
                    if (free_way == '0) begin
                        repl_use     = 1'b1;
                        mshr_nxt.way = {{(DCACHE_SET_ASSOC-1){1'b0}}, 1'b1} << repl_way;
                    end else begin
                        mshr_nxt.way = free_way;
                    end
                    rr_ptr_nxt = (win == NumPorts-1) ? '0 : PW'(win + 1);
                    state_nxt  = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) state_nxt = WAIT_RTRN;
            end
            WAIT_RTRN: begin
                if (mem_rtrn_vld_i && mem_rtrn_tid_i == MemTid) begin
                    for (int i = 0; i < NumPorts; i++) begin
                        miss_rtrn_vld_o[i] = (mshr.owner == OWNER_W'(i));
                    end
                    wr_cl_vld_o = !mshr.nc;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            mshr   <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            mshr   <= mshr_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    assign mem_paddr_o = mshr.paddr;
    assign mem_size_o  = mshr.size;
    assign mem_nc_o    = mshr.nc;
    assign mem_tid_o   = MemTid;
    assign wr_cl_way_o = mshr.way;
    assign wr_cl_idx_o = mshr.paddr[DCACHE_OFFSET_WIDTH +: DCACHE_CL_IDX_WIDTH];
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_wt_dcache_miss_resp.sv
// Scoreboard bench for wt_dcache_miss_resp: expected refills queued at grant, checked at memory side.
// Replacement expectations follow WT_DCACHE_MISS_LFSR_EN the same way the design does.
module tb_wt_dcache_miss_resp;
    import wt_cache_pkg::*;

    localparam logic [2:0] MEM_TID = 3'd1;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [2:0]  miss_req_i = '0;
    logic [2:0]  miss_ack_o, miss_replay_o, miss_rtrn_vld_o;
    logic [31:0] miss_paddr_i [3];
    logic [3:0]  miss_vld_bits_i [3];
    logic [2:0]  miss_nc_i = '0;
    logic [2:0]  miss_size_i [3];
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_paddr_o;
    logic [2:0]  mem_size_o;
    logic        mem_nc_o;
    logic [2:0]  mem_tid_o;
    logic        mem_rtrn_vld_i = 1'b0;
    logic [2:0]  mem_rtrn_tid_i = '0;
    logic        wr_cl_vld_o;
    logic [3:0]  wr_cl_way_o;
    logic [6:0]  wr_cl_idx_o;
    logic        busy_o;

    typedef struct {
        logic [31:0] paddr;
        logic [2:0]  size;
        logic        nc;
        int          owner;
        logic [3:0]  way;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic [1:0] repl_cnt = '0;

    always #5 clk = ~clk;

    wt_dcache_miss_resp #(.NumPorts(3), .MemTid(MEM_TID)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .miss_req_i      (miss_req_i),
        .miss_ack_o      (miss_ack_o),
        .miss_replay_o   (miss_replay_o),
        .miss_rtrn_vld_o (miss_rtrn_vld_o),
        .miss_paddr_i    (miss_paddr_i),
        .miss_vld_bits_i (miss_vld_bits_i),
        .miss_nc_i       (miss_nc_i),
        .miss_size_i     (miss_size_i),
        .mem_req_o       (mem_req_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_paddr_o     (mem_paddr_o),
        .mem_size_o      (mem_size_o),
        .mem_nc_o        (mem_nc_o),
        .mem_tid_o       (mem_tid_o),
        .mem_rtrn_vld_i  (mem_rtrn_vld_i),
        .mem_rtrn_tid_i  (mem_rtrn_tid_i),
        .wr_cl_vld_o     (wr_cl_vld_o),
        .wr_cl_way_o     (wr_cl_way_o),
        .wr_cl_idx_o     (wr_cl_idx_o),
        .busy_o          (busy_o)
    );

`ifdef WT_DCACHE_MISS_LFSR_EN
    logic [7:0] lfsr_m;
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) lfsr_m <= 8'hA5;
        else         lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
`endif

    function automatic logic [3:0] exp_way(input logic [3:0] vld);
        logic [3:0] w;
        for (int b = 0; b < 4; b++) if (!vld[b]) return 4'b0001 << b;
`ifdef WT_DCACHE_MISS_LFSR_EN
        w = 4'b0001 << lfsr_m[1:0];
`else
        w = 4'b0001 << repl_cnt;
        repl_cnt = repl_cnt + 2'd1;
`endif
        return w;
    endfunction

    function automatic exp_t make_exp(input int port, input logic [31:0] pa,
                                      input logic [3:0] vld, input logic nc, input logic [2:0] sz);
        exp_t e;
        e.paddr = nc ? pa : {pa[31:5], 5'b0};
        e.size  = nc ? sz : 3'b111;
        e.nc    = nc;
        e.owner = port;
        e.way   = exp_way(vld);
        return e;
    endfunction

    task automatic set_port(input int port, input logic [31:0] pa, input logic [3:0] vld,
                            input logic nc, input logic [2:0] sz);
        miss_paddr_i[port]    = pa;
        miss_vld_bits_i[port] = vld;
        miss_nc_i[port]       = nc;
        miss_size_i[port]     = sz;
        miss_req_i[port]      = 1'b1;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        miss_req_i = '0; mem_gnt_i = 1'b0; mem_rtrn_vld_i = 1'b0; mem_rtrn_tid_i = '0;
        for (int p = 0; p < 3; p++) begin
            miss_paddr_i[p] = '0; miss_vld_bits_i[p] = '0; miss_size_i[p] = '0;
        end
        miss_nc_i = '0;
        exp_q.delete();
        repl_cnt = '0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk); #1;
    endtask

    // Single requester at posedge+1: expects the ack in the same cycle.
    task automatic request_grant(input int port, input logic [31:0] pa, input logic [3:0] vld,
                                 input logic nc, input logic [2:0] sz);
        exp_t e;
        set_port(port, pa, vld, nc, sz);
        #1;
        e = make_exp(port, pa, vld, nc, sz);
        n_checks++;
        if (miss_ack_o !== (3'b001 << port) || miss_replay_o !== 3'b000) begin
            $display("FAIL req_ack port=%0d ack=%b replay=%b want ack=%b replay=000",
                     port, miss_ack_o, miss_replay_o, 3'b001 << port);
        end else n_pass++;
        exp_q.push_back(e);
        @(posedge clk); #1;
        miss_req_i[port] = 1'b0;
    endtask

    // Drives grant, a foreign-tid return, then the real return for the oldest queued miss.
    task automatic serve_miss();
        exp_t e;
        int cyc;
        cyc = 0;
        while (mem_req_o !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        n_checks++;
        if (mem_req_o !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL serve_start mem_req=%b queued=%0d want mem_req=1 queued>0",
                     mem_req_o, exp_q.size());
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            return;
        end
        n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (mem_paddr_o !== e.paddr || mem_size_o !== e.size || mem_nc_o !== e.nc || mem_tid_o !== MEM_TID) begin
            $display("FAIL mem_fields paddr=%h size=%b nc=%b tid=%0d want paddr=%h size=%b nc=%b tid=%0d",
                     mem_paddr_o, mem_size_o, mem_nc_o, mem_tid_o, e.paddr, e.size, e.nc, MEM_TID);
        end else n_pass++;
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 3'd2;
        #1;
        n_checks++;
        if (mem_req_o !== 1'b0 || busy_o !== 1'b1 || miss_rtrn_vld_o !== 3'b000 ||
            wr_cl_vld_o !== 1'b0 || miss_ack_o !== 3'b000) begin
            $display("FAIL foreign_tid req=%b busy=%b rtrn=%b wr=%b ack=%b want 0 1 000 0 000",
                     mem_req_o, busy_o, miss_rtrn_vld_o, wr_cl_vld_o, miss_ack_o);
        end else n_pass++;
        @(posedge clk); #1;
        mem_rtrn_tid_i = MEM_TID;
        #1;
        n_checks++;
        if (miss_rtrn_vld_o !== (3'b001 << e.owner) || wr_cl_vld_o !== !e.nc || miss_ack_o !== 3'b000) begin
            $display("FAIL return rtrn=%b wr=%b ack=%b want rtrn=%b wr=%b ack=000",
                     miss_rtrn_vld_o, wr_cl_vld_o, miss_ack_o, 3'b001 << e.owner, !e.nc);
        end else n_pass++;
        if (!e.nc) begin
            n_checks++;
            if (wr_cl_way_o !== e.way || wr_cl_idx_o !== e.paddr[11:5]) begin
                $display("FAIL refill_way way=%b idx=%h want way=%b idx=%h",
                         wr_cl_way_o, wr_cl_idx_o, e.way, e.paddr[11:5]);
            end else n_pass++;
        end
        @(posedge clk); #1;
        mem_rtrn_vld_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (miss_ack_o !== 3'b000 || miss_replay_o !== 3'b000 || miss_rtrn_vld_o !== 3'b000 ||
            mem_req_o !== 1'b0 || wr_cl_vld_o !== 1'b0 || busy_o !== 1'b0) begin
            $display("FAIL reset_ctrl ack=%b rep=%b rtrn=%b req=%b wr=%b busy=%b want all zero",
                     miss_ack_o, miss_replay_o, miss_rtrn_vld_o, mem_req_o, wr_cl_vld_o, busy_o);
        end else n_pass++;
        n_checks++;
        if (mem_paddr_o !== 32'h0 || mem_size_o !== 3'b000 || mem_tid_o !== MEM_TID) begin
            $display("FAIL reset_data paddr=%h size=%b tid=%0d want 0 000 %0d",
                     mem_paddr_o, mem_size_o, mem_tid_o, MEM_TID);
        end else n_pass++;
        @(posedge clk); #1 rst_ni = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cacheable();
        request_grant(0, 32'h8000_1048, 4'b0111, 1'b0, 3'd3);
        serve_miss();
    endtask

    task automatic test_nc();
        request_grant(1, 32'h1000_0004, 4'b0000, 1'b1, 3'd2);
        serve_miss();
    endtask

    task automatic test_round_robin();
        exp_t e;
        apply_reset();
        for (int p = 0; p < 3; p++) set_port(p, 32'h8000_0000 + p * 32'h2000, 4'b0000, 1'b0, 3'd3);
        for (int p = 0; p < 3; p++) begin
            #1;
            n_checks++;
            if (miss_ack_o !== (3'b001 << p)) begin
                $display("FAIL rr_order step=%0d ack=%b want %b", p, miss_ack_o, 3'b001 << p);
            end else n_pass++;
            e = make_exp(p, miss_paddr_i[p], 4'b0000, 1'b0, 3'd3);
            exp_q.push_back(e);
            @(posedge clk); #1;
            miss_req_i[p] = 1'b0;
            serve_miss();
        end
    endtask

    task automatic test_replay();
        exp_t e;
        request_grant(0, 32'h8000_1048, 4'b0111, 1'b0, 3'd3);
        e = exp_q.pop_front();
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_paddr_o !== e.paddr) begin
            $display("FAIL replay_memreq req=%b paddr=%h want 1 %h", mem_req_o, mem_paddr_o, e.paddr);
        end else n_pass++;
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        set_port(2, 32'h8000_1050, 4'b0000, 1'b0, 3'd3);
        set_port(1, 32'h8000_3000, 4'b0000, 1'b0, 3'd3);
        #1;
        n_checks++;
        if (miss_replay_o !== 3'b100 || miss_ack_o !== 3'b000) begin
            $display("FAIL replay_wait replay=%b ack=%b want 100 000", miss_replay_o, miss_ack_o);
        end else n_pass++;
        @(posedge clk); #1;
        miss_req_i[2] = 1'b0;
        mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = MEM_TID;
        miss_req_i[2] = 1'b1;
        #1;
        n_checks++;
        if (miss_rtrn_vld_o !== 3'b001 || wr_cl_vld_o !== 1'b1 || miss_replay_o !== 3'b100 ||
            miss_ack_o !== 3'b000 || wr_cl_way_o !== 4'b1000) begin
            $display("FAIL replay_rtrn rtrn=%b wr=%b replay=%b ack=%b way=%b want 001 1 100 000 1000",
                     miss_rtrn_vld_o, wr_cl_vld_o, miss_replay_o, miss_ack_o, wr_cl_way_o);
        end else n_pass++;
        @(posedge clk); #1;
        mem_rtrn_vld_i = 1'b0;
        #1;
        n_checks++;
        if (miss_ack_o !== 3'b010 || miss_replay_o !== 3'b000 || busy_o !== 1'b0) begin
            $display("FAIL replay_next ack=%b replay=%b busy=%b want 010 000 0",
                     miss_ack_o, miss_replay_o, busy_o);
        end else n_pass++;
        e = make_exp(1, 32'h8000_3000, 4'b0000, 1'b0, 3'd3);
        exp_q.push_back(e);
        @(posedge clk); #1;
        miss_req_i = '0;
        serve_miss();
    endtask

    task automatic test_repl();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            request_grant(0, 32'h8001_0000 + i * 32'h20, 4'b1111, 1'b0, 3'd3);
            serve_miss();
        end
    endtask

    task automatic test_reset_mid();
        request_grant(1, 32'h8000_5000, 4'b0000, 1'b0, 3'd3);
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            $display("FAIL rst_mid_async busy=%b req=%b want 0 0", busy_o, mem_req_o);
        end else n_pass++;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        exp_q.delete();
        repl_cnt = '0;
        @(posedge clk); #1;
        mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = MEM_TID;
        #1;
        n_checks++;
        if (miss_rtrn_vld_o !== 3'b000 || wr_cl_vld_o !== 1'b0 || busy_o !== 1'b0) begin
            $display("FAIL rst_mid_late rtrn=%b wr=%b busy=%b want 000 0 0",
                     miss_rtrn_vld_o, wr_cl_vld_o, busy_o);
        end else n_pass++;
        @(posedge clk); #1;
        mem_rtrn_vld_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cacheable();
        test_nc();
        test_round_robin();
        test_replay();
        test_repl();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d checks=%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
